csr_rmw_unit: RTL and testbench
===============================

// Module: csr_rmw_unit
// PURPOSE
//  Parametrised CSR read-modify-write unit: register storage, RW/RS/RC update, read-only counters, response handshake.
//  Accepts one CSR instruction per cycle from the EX stage and returns the old CSR value one cycle later.
//  Suppresses writes for RS/RC with a zero source and flags illegal accesses.
//  Holds NUM_CSR generic RW registers plus free-running cycle/instret counters.
// PARAMETERS
//  XLEN      32      data width of CSRs, rs1 and response data
//  NUM_CSR   8       number of generic RW CSRs, mapped at CSR_BASE .. CSR_BASE+NUM_CSR-1
//  CSR_BASE  12'h340 address of generic CSR 0
//  CNT_W     64      width of cycle/instret counters (XLEN <= CNT_W <= 2*XLEN)
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  req_valid    in   1     CSR request present
//  req_ready    out  1     unit can accept; = !resp_valid || resp_ready
//  req_op       in   3     funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//  req_addr     in   12    CSR address
//  req_rs1      in   XLEN  register source value (ops 001-011)
//  req_zimm     in   5     immediate source, zero-extended to XLEN (ops 101-111)
//  req_src_x0   in   1     source field is x0 / zimm==0 (write-suppress qualifier)
//  retire       in   1     one instruction retired this cycle (instret increment)
//  resp_valid   out  1     response holds result of an accepted request
//  resp_ready   in   1     consumer takes response
//  resp_rdata   out  XLEN  old CSR value (0 when illegal)
//  resp_illegal out  1     request was illegal; no state changed
// BEHAVIOUR
//  Reset (rst_n=0, async): resp_valid=0, resp_rdata=0, resp_illegal=0, all CSRs=0, cycle=0, instret=0.
//  Accept: fire = req_valid && req_ready. On the fire edge: CSR read (old value), RMW write, response registered.
//  Latency 1: resp_valid rises the cycle after fire; held with stable data until resp_valid && resp_ready.
//  Throughput 1/cycle when resp_ready=1; back-to-back requests to the same CSR see the previous write.
//  Source S = op[2] ? {{XLEN-5{1'b0}},zimm} : rs1. New value: RW: S; RS: old|S; RC: old&~S.
//  Write enable: RW/RWI always; RS/RC/RSI/RCI only when req_src_x0=0.
//  Address map: CSR_BASE+i -> generic reg i; 12'hC00 cycle low, 12'hC80 cycle high,
//    12'hC02 instret low, 12'hC82 instret high. Low = cnt[XLEN-1:0]; high = cnt[CNT_W-1:XLEN] zero-extended.
//  High addresses are unmapped if CNT_W == XLEN.
//  Illegal (resp_illegal=1, rdata=0, no write): unmapped address; op 000 or 100;
//    write enabled to an address with addr[11:10]==2'b11 (read-only space).
//  RS/RC with req_src_x0=1 to a counter is a legal pure read.
//  cycle: +1 every clock after reset. instret: +1 when retire=1. Both wrap 2^CNT_W-1 -> 0 with no flag.
//  Counter read returns the value before this edge's increment.
//  Stall: resp_valid=1 && resp_ready=0 -> req_ready=0; no fire, no write. Counters keep counting.
//  Reset mid-operation: pending response dropped; next fire after release behaves as first access.
// TESTING
//  1 Reset, then RW 0x340 rs1=0xDEADBEEF; read via RS src_x0=1 -> rdata 0, then rdata 0xDEADBEEF.
//  2 0x341=0x0000_00F0; RS rs1=0x0F -> rdata 0xF0, reg=0xFF; RCI zimm=0x03 -> rdata 0xFF, reg=0xFC.
//  3 Back-to-back RW 0x342: 0x1, then 0x2 with resp_ready=1 -> rdatas 0x0, 0x1; reg=0x2; no bubbles.
//  4 resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, resp held, reg unchanged; then resp_ready=1 -> resumes.
//  5 RW 0xC00 -> resp_illegal=1, rdata 0, cycle unchanged; RS 0xC00 src_x0=1 -> legal, rdata = cycles since reset.
//  6 Force instret=0xFFFF_FFFF_FFFF_FFFF, retire=1 -> reads 0 at 0xC02 and 0xC82; unmapped 0x7FF -> illegal.

Source files
------------

// File: rtl/csr_rmw_unit.sv
// CSR read-modify-write unit: NUM_CSR generic RW registers plus read-only cycle/instret counters.
// Latency 1 cycle; req_ready drops while a registered response is waiting for resp_ready.
module csr_rmw_unit #(
  parameter int          XLEN     = 32,
  parameter int          NUM_CSR  = 8,
  parameter logic [11:0] CSR_BASE = 12'h340,
  parameter int          CNT_W    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [4:0]      req_zimm,
  input  logic            req_src_x0,
  input  logic            retire,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal
);
  localparam int IDX_W  = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
  localparam bit HAS_HI = (CNT_W > XLEN);

  logic [XLEN-1:0]  regs [NUM_CSR];
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic [XLEN-1:0]  cycle_hi;
  logic [XLEN-1:0]  instret_hi;
  logic [11:0]      off;
  logic [IDX_W-1:0] idx;
  logic             is_gen;
  logic             mapped;
  logic             wr_en;
  logic             illegal;
  logic             fire;
  logic [XLEN-1:0]  src;
  logic [XLEN-1:0]  old_val;
  logic [XLEN-1:0]  new_val;

  assign req_ready = !resp_valid || resp_ready;
  assign fire      = req_valid && req_ready;

  assign off    = req_addr - CSR_BASE;
  assign idx    = off[IDX_W-1:0];
  assign is_gen = int'(off) < NUM_CSR;

  // Shifting by XLEN yields zero when CNT_W == XLEN, so no illegal slice is needed.
  assign cycle_hi   = XLEN'(cycle_cnt >> XLEN);
  assign instret_hi = XLEN'(instret_cnt >> XLEN);

  always_comb begin
    mapped  = 1'b1;
    old_val = '0;
    if (is_gen) begin
      old_val = regs[idx];
    end else begin
      case (req_addr)
        12'hC00: old_val = cycle_cnt[XLEN-1:0];
        12'hC80: begin old_val = cycle_hi;   mapped = HAS_HI; end
        12'hC02: old_val = instret_cnt[XLEN-1:0];
        12'hC82: begin old_val = instret_hi; mapped = HAS_HI; end
        default: mapped = 1'b0;
      endcase
    end
  end

  assign src     = req_op[2] ? XLEN'(req_zimm) : req_rs1;
  // RS/RC with an x0/zero source is a pure read and must not trip the read-only check.
  assign wr_en   = (req_op[1:0] == 2'b01) || !req_src_x0;
  assign illegal = !mapped || (req_op[1:0] == 2'b00) || (wr_en && req_addr[11:10] == 2'b11);

  always_comb begin
    case (req_op[1:0])
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = src;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CSR; i++) regs[i] <= '0;
    end else if (fire && !illegal && wr_en && is_gen) begin
      regs[idx] <= new_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_illegal <= 1'b0;
    end else begin
      if (resp_valid && resp_ready) resp_valid <= 1'b0;
      if (fire) begin
        resp_valid   <= 1'b1;
        resp_rdata   <= illegal ? '0 : old_val;
        resp_illegal <= illegal;
      end
    end
  end
endmodule

// File: tb/tb_csr_rmw_unit.sv
// Bench for csr_rmw_unit: directed scenarios plus random traffic against a behavioural model,
// and a narrow-counter instance used to exercise counter wrap-around.
module tb_csr_rmw_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_src_x0, retire;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_rs1;
  logic [4:0]  req_zimm;
  logic        resp_valid, resp_ready, resp_illegal;
  logic [31:0] resp_rdata;

  logic        s_req_valid, s_req_ready, s_req_src_x0, s_retire;
  logic [2:0]  s_req_op;
  logic [11:0] s_req_addr;
  logic [7:0]  s_req_rs1;
  logic [4:0]  s_req_zimm;
  logic        s_resp_valid, s_resp_ready, s_resp_illegal;
  logic [7:0]  s_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  csr_rmw_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_rs1(req_rs1), .req_zimm(req_zimm),
    .req_src_x0(req_src_x0), .retire(retire), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal)
  );

  csr_rmw_unit #(.XLEN(8), .NUM_CSR(4), .CSR_BASE(12'h340), .CNT_W(16)) sdut (
    .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_op(s_req_op), .req_addr(s_req_addr), .req_rs1(s_req_rs1), .req_zimm(s_req_zimm),
    .req_src_x0(s_req_src_x0), .retire(s_retire), .resp_valid(s_resp_valid),
    .resp_ready(s_resp_ready), .resp_rdata(s_resp_rdata), .resp_illegal(s_resp_illegal)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_reg [8];
  logic [63:0] m_cycle = 0, m_instret = 0;
  logic        m_rv = 0, m_ill = 0;
  logic [31:0] m_rdata = 0;
  logic [15:0] s_cyc = 0, s_ins = 0;
  logic [7:0]  s_exp = 0;
  logic        s_exp_ill = 0;

  logic        mf, found, wr, ill;
  logic [31:0] src, old, nv;
  int          idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rv = 0; m_rdata = 0; m_ill = 0; m_cycle = 0; m_instret = 0;
      foreach (m_reg[i]) m_reg[i] = 0;
      s_cyc = 0; s_ins = 0; s_exp = 0; s_exp_ill = 0;
    end else begin
      mf = req_valid && (!m_rv || resp_ready);
      if (m_rv && resp_ready) m_rv = 0;
      if (mf) begin
        src   = (req_op >= 3'd5) ? 32'(req_zimm) : req_rs1;
        wr    = (req_op == 3'd1) || (req_op == 3'd5) || !req_src_x0;
        found = 1; old = 0; idx = int'(req_addr) - 'h340;
        if (idx >= 0 && idx < 8)     old = m_reg[idx];
        else if (req_addr == 12'hC00) old = m_cycle[31:0];
        else if (req_addr == 12'hC80) old = m_cycle[63:32];
        else if (req_addr == 12'hC02) old = m_instret[31:0];
        else if (req_addr == 12'hC82) old = m_instret[63:32];
        else found = 0;
        ill = !found || req_op == 3'd0 || req_op == 3'd4 || (wr && req_addr >= 12'hC00);
        m_rv = 1; m_rdata = ill ? 32'd0 : old; m_ill = ill;
        if (!ill && wr && idx >= 0 && idx < 8) begin
          case (req_op)
            3'd2, 3'd6: nv = old | src;
            3'd3, 3'd7: nv = old & ~src;
            default:    nv = src;
          endcase
          m_reg[idx] = nv;
        end
      end
      m_cycle = m_cycle + 1;
      if (retire) m_instret = m_instret + 1;
      if (s_req_valid) begin
        wr = (s_req_op == 3'd1) || (s_req_op == 3'd5) || !s_req_src_x0;
        found = 1; s_exp = 0;
        if (s_req_addr == 12'hC00)      s_exp = s_cyc[7:0];
        else if (s_req_addr == 12'hC80) s_exp = s_cyc[15:8];
        else if (s_req_addr == 12'hC02) s_exp = s_ins[7:0];
        else if (s_req_addr == 12'hC82) s_exp = s_ins[15:8];
        else found = 0;
        s_exp_ill = !found || (wr && s_req_addr >= 12'hC00);
        if (s_exp_ill) s_exp = 0;
      end
      s_cyc = s_cyc + 1;
      if (s_retire) s_ins = s_ins + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check("req_ready", req_ready, !m_rv || resp_ready);
    check("resp_valid", resp_valid, m_rv);
    if (m_rv) begin
      check("resp_rdata", resp_rdata, m_rdata);
      check("resp_illegal", resp_illegal, m_ill);
    end
    retire = 1'($urandom_range(0, 1));
  endtask

  task automatic req(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] rs1,
                     input logic [4:0] zimm, input logic x0);
    logic go;
    req_valid = 1; req_op = op; req_addr = addr; req_rs1 = rs1; req_zimm = zimm; req_src_x0 = x0;
    for (int n = 0; n < 20; n++) begin
      go = !m_rv || resp_ready;
      cyc();
      if (go) return;
    end
    n_checks++; n_fail++;
    $display("FAIL req_timeout: request to 0x%0h not accepted within 20 cycles", addr);
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) cyc();
  endtask

  task automatic s_read(input logic [2:0] op, input logic [11:0] addr, input logic x0);
    s_req_valid = 1; s_req_op = op; s_req_addr = addr; s_req_src_x0 = x0;
    @(negedge clk);
    s_req_valid = 0;
    check("s_resp_valid", s_resp_valid, 1);
    check("s_resp_rdata", s_resp_rdata, s_exp);
    check("s_resp_illegal", s_resp_illegal, s_exp_ill);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] cnt_addr [4];
    cnt_addr = '{12'hC00, 12'hC80, 12'hC02, 12'hC82};
    rst_n = 0; req_valid = 0; req_op = 0; req_addr = 0; req_rs1 = 0; req_zimm = 0;
    req_src_x0 = 0; retire = 0; resp_ready = 1;
    s_req_valid = 0; s_req_op = 0; s_req_addr = 0; s_req_rs1 = 0; s_req_zimm = 0;
    s_req_src_x0 = 0; s_retire = 0; s_resp_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_illegal", resp_illegal, 0);
    check("rst_req_ready", req_ready, 1);
    rst_n = 1;

    // Basic RW then read-back
    req(3'd1, 12'h340, 32'hDEADBEEF, 0, 0);
    req(3'd2, 12'h340, 32'h0, 0, 1);
    idle(2);
    // RS and RCI updates
    req(3'd1, 12'h341, 32'h0000_00F0, 0, 0);
    req(3'd2, 12'h341, 32'h0000_000F, 0, 0);
    req(3'd7, 12'h341, 32'h0, 5'h03, 0);
    req(3'd2, 12'h341, 32'h0, 0, 1);
    // Back-to-back to the same CSR
    req(3'd1, 12'h342, 32'h1, 0, 0);
    req(3'd1, 12'h342, 32'h2, 0, 0);
    req(3'd2, 12'h342, 32'h0, 0, 1);
    idle(1);
    // Stall: response held, next request blocked
    req(3'd1, 12'h343, 32'hAA, 0, 0);
    resp_ready = 0;
    req_valid = 1; req_op = 3'd1; req_addr = 12'h343; req_rs1 = 32'hBB; req_src_x0 = 0;
    repeat (3) cyc();
    resp_ready = 1;
    cyc();
    req(3'd2, 12'h343, 32'h0, 0, 1);
    idle(1);
    // Counters and illegal accesses
    req(3'd1, 12'hC00, 32'h5, 0, 0);
    req(3'd2, 12'hC00, 32'h0, 0, 1);
    req(3'd3, 12'hC80, 32'h0, 0, 1);
    req(3'd6, 12'hC02, 32'h0, 0, 1);
    req(3'd2, 12'hC02, 32'h5, 0, 0);
    req(3'd0, 12'h340, 32'h5, 0, 0);
    req(3'd4, 12'h340, 32'h5, 0, 0);
    req(3'd1, 12'h348, 32'h5, 0, 0);
    req(3'd2, 12'h7FF, 32'h0, 0, 1);
    idle(2);

    // Reset while a response is pending
    req(3'd1, 12'h344, 32'h1234, 0, 0);
    resp_ready = 0; req_valid = 0;
    #2 rst_n = 0;
    #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_resp_rdata", resp_rdata, 0);
    check("midrst_resp_illegal", resp_illegal, 0);
    check("midrst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1; resp_ready = 1;
    req(3'd2, 12'h344, 32'h0, 0, 1);
    req(3'd2, 12'h340, 32'h0, 0, 1);
    idle(1);

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      cyc();
      req_valid  = ($urandom_range(0, 9) < 7);
      resp_ready = ($urandom_range(0, 3) != 0);
      req_op     = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0, 1, 2: req_addr = 12'h340 + 12'($urandom_range(0, 9));
        3, 4:    req_addr = cnt_addr[$urandom_range(0, 3)];
        default: req_addr = 12'($urandom);
      endcase
      req_rs1    = $urandom;
      req_zimm   = 5'($urandom);
      req_src_x0 = ($urandom_range(0, 3) == 0);
    end
    resp_ready = 1;
    idle(3);

    // Counter wrap on the narrow instance: 65536 retires bring instret back to 0
    s_retire = 1;
    repeat (65534) @(negedge clk);
    s_read(3'd2, 12'hC82, 1);
    s_retire = 0;
    s_read(3'd2, 12'hC02, 1);
    s_read(3'd2, 12'hC82, 1);
    s_read(3'd3, 12'hC00, 1);
    s_read(3'd6, 12'hC80, 1);
    s_read(3'd1, 12'hC02, 0);
    s_read(3'd2, 12'h7FF, 1);
    check("s_resp_valid_drop", s_resp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
